// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: queues committed {pc, inst, wbData} records and streams each one
// as a SYNC-led little-endian byte frame. Define COMMIT_TX_SEQ_EN to add a per-commit sequence byte.
module commit_trace_tx #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_start,
  input  logic        io_in_commit,
  input  logic [31:0] io_in_pc,
  input  logic [31:0] io_in_inst,
  input  logic [31:0] io_in_wbData,
  output logic        io_out_valid,
  input  logic        io_in_ready,
  output logic [7:0]  io_out_byte,
  output logic        io_out_overflow,
  output logic [15:0] io_out_dropCnt,
  output logic        io_out_busy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef COMMIT_TX_SEQ_EN
  localparam int unsigned RecW     = 104;
  localparam int unsigned NumBytes = 14;
`else
  localparam int unsigned RecW     = 96;
  localparam int unsigned NumBytes = 13;
`endif
  localparam int unsigned FrameW  = 8 * NumBytes;
  localparam logic [3:0]  LastIdx = 4'(NumBytes - 1);
  localparam logic [PtrW:0] Full  = (PtrW + 1)'(DEPTH);

  typedef enum logic {StIdle, StSend} state_e;

  state_e             state_q, state_d;
  logic [RecW-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]      count_q, count_d;
  logic [FrameW-1:0]  frame_q, frame_d;
  logic [3:0]         idx_q, idx_d;
  logic               overflow_q;
  logic [15:0]        drop_cnt_q;
  logic               push_req, push, pop, drop;
  logic [RecW-1:0]    wr_rec, head;

  // Records are stored in frame order above the SYNC byte, so loading is a plain concatenation.
`ifdef COMMIT_TX_SEQ_EN
  logic [7:0] seq_q;
  assign wr_rec = {io_in_wbData, io_in_inst, io_in_pc, seq_q};
`else
  assign wr_rec = {io_in_wbData, io_in_inst, io_in_pc};
`endif

  assign push_req = io_in_start & io_in_commit;
  assign head     = mem_q[rd_ptr_q];
  assign push     = push_req & ((count_q != Full) | pop);
  assign drop     = push_req & ~push;
  assign count_d  = count_q + (PtrW + 1)'(push) - (PtrW + 1)'(pop);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          frame_d = {head, SYNC_BYTE};
          idx_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (io_in_ready) begin
          if (idx_q == LastIdx) begin
            idx_d = '0;
            // Back-to-back: next record loads on the same edge that retires the last byte.
            if (count_q != '0) begin
              pop     = 1'b1;
              frame_d = {head, SYNC_BYTE};
            end else begin
              frame_d = '0;
              state_d = StIdle;
            end
          end else begin
            frame_d = frame_q >> 8;
            idx_d   = idx_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= wr_rec;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      frame_q    <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      frame_q  <= frame_d;
      idx_q    <= idx_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

`ifdef COMMIT_TX_SEQ_EN
  // Counts every capture attempt, so drops show up as gaps in the emitted sequence.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        seq_q <= '0;
    else if (push_req) seq_q <= seq_q + 8'd1;
  end
`endif

  assign io_out_valid    = (state_q == StSend);
  assign io_out_byte     = frame_q[7:0];
  assign io_out_overflow = overflow_q;
  assign io_out_dropCnt  = drop_cnt_q;
  assign io_out_busy     = (count_q != '0) || (state_q != StIdle);

endmodule

// File: tb/tb_commit_trace_tx.sv
// Bench for commit_trace_tx: queue-based reference model checked every cycle, plus directed
// scenarios with hand-written expectations. Honours COMMIT_TX_SEQ_EN for the 14-byte frame.
module tb_commit_trace_tx;

  localparam int DEPTH = 4;
`ifdef COMMIT_TX_SEQ_EN
  localparam int NB = 14;
`else
  localparam int NB = 13;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_in_start = 1'b0, io_in_commit = 1'b0, io_in_ready = 1'b0;
  logic [31:0] io_in_pc = '0, io_in_inst = '0, io_in_wbData = '0;
  logic        io_out_valid, io_out_overflow, io_out_busy;
  logic [7:0]  io_out_byte;
  logic [15:0] io_out_dropCnt;

  commit_trace_tx #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_in_start    (io_in_start),
    .io_in_commit   (io_in_commit),
    .io_in_pc       (io_in_pc),
    .io_in_inst     (io_in_inst),
    .io_in_wbData   (io_in_wbData),
    .io_out_valid   (io_out_valid),
    .io_in_ready    (io_in_ready),
    .io_out_byte    (io_out_byte),
    .io_out_overflow(io_out_overflow),
    .io_out_dropCnt (io_out_dropCnt),
    .io_out_busy    (io_out_busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending records and the bytes still to send of the current frame.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] wb;
    logic [7:0]  seq;
  } rec_t;

  rec_t        mq[$];
  logic [7:0]  fq[$];
  int          m_drop = 0;
  bit          m_ovf = 0;
  logic [7:0]  m_seq = 0;
  logic [7:0]  log_q[$];

  task automatic load(input rec_t r);
    fq.delete();
    fq.push_back(8'hA5);
`ifdef COMMIT_TX_SEQ_EN
    fq.push_back(r.seq);
`endif
    for (int i = 0; i < 4; i++) fq.push_back(r.pc[8*i +: 8]);
    for (int i = 0; i < 4; i++) fq.push_back(r.inst[8*i +: 8]);
    for (int i = 0; i < 4; i++) fq.push_back(r.wb[8*i +: 8]);
  endtask

  always @(negedge reset) begin
    mq.delete();
    fq.delete();
    m_drop = 0;
    m_ovf  = 0;
    m_seq  = 0;
  end

  always @(posedge clock) begin : model
    bit   acc, last, pop, preq;
    rec_t r;
    if (reset) begin
      acc  = (fq.size() > 0) && io_in_ready;
      last = acc && (fq.size() == 1);
      pop  = (mq.size() > 0) && ((fq.size() == 0) || last);
      preq = io_in_start && io_in_commit;
      r.pc = io_in_pc; r.inst = io_in_inst; r.wb = io_in_wbData; r.seq = m_seq;
      if (acc) void'(fq.pop_front());
      if (pop) load(mq.pop_front());
      if (preq) begin
        if ((mq.size() < DEPTH) || pop) mq.push_back(r);
        else begin
          m_ovf = 1;
          if (m_drop != 16'hFFFF) m_drop++;
        end
        m_seq++;
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of accepted bytes.
  always @(negedge clock) begin
    if (reset) begin
      check("valid", {31'b0, io_out_valid}, {31'b0, fq.size() > 0});
      if (fq.size() > 0) check("byte", {24'b0, io_out_byte}, {24'b0, fq[0]});
      check("busy", {31'b0, io_out_busy}, {31'b0, (mq.size() > 0) || (fq.size() > 0)});
      check("overflow", {31'b0, io_out_overflow}, {31'b0, m_ovf});
      check("dropCnt", {16'b0, io_out_dropCnt}, m_drop);
      if (io_out_valid && io_in_ready) log_q.push_back(io_out_byte);
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic commit(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] wb);
    io_in_commit = 1'b1; io_in_pc = pc; io_in_inst = inst; io_in_wbData = wb;
    cyc();
    io_in_commit = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    io_in_ready = 1'b1;
    while (io_out_busy && n < 1000) begin cyc(); n++; end
    check({name, "_drain_timeout"}, {31'b0, io_out_busy}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_valid", {31'b0, io_out_valid}, 32'd0);
    check("rst_byte", {24'b0, io_out_byte}, 32'd0);
    check("rst_busy", {31'b0, io_out_busy}, 32'd0);
    check("rst_overflow", {31'b0, io_out_overflow}, 32'd0);
    check("rst_dropCnt", {16'b0, io_out_dropCnt}, 32'd0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
  endtask

  logic [7:0] exp1 [NB];
  logic [7:0] seqs [6];

  initial begin
    int n;
    int drop_before;
    do_reset();
    io_in_start = 1'b1;

    // Single commit with latency check.
`ifdef COMMIT_TX_SEQ_EN
    exp1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h93, 8'h00, 8'h10, 8'h00,
             8'h01, 8'h00, 8'h00, 8'h00};
`else
    exp1 = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h80, 8'h93, 8'h00, 8'h10, 8'h00, 8'h01,
             8'h00, 8'h00, 8'h00};
`endif
    log_q.delete();
    io_in_ready = 1'b1;
    commit(32'h8000_0000, 32'h0010_0093, 32'd1);
    check("lat_n1_valid", {31'b0, io_out_valid}, 32'd0);
    cyc();
    check("lat_n2_valid", {31'b0, io_out_valid}, 32'd1);
    check("lat_n2_sync", {24'b0, io_out_byte}, 32'hA5);
    repeat (NB + 3) cyc();
    check("single_len", log_q.size(), NB);
    for (int i = 0; i < NB && i < log_q.size(); i++)
      check($sformatf("single_b%0d", i), {24'b0, log_q[i]}, {24'b0, exp1[i]});
    check("single_valid_after", {31'b0, io_out_valid}, 32'd0);
    check("single_busy_after", {31'b0, io_out_busy}, 32'd0);

    // Backpressure mid-frame: same frame bytes expected in order.
    log_q.delete();
    commit(32'h8000_0000, 32'h0010_0093, 32'd1);
    for (int i = 0; i < 24; i++) begin
      io_in_ready = (i % 4 == 0) || (i % 4 == 3);
      cyc();
    end
    drain("bp");
    check("bp_len", log_q.size(), NB);
    for (int i = 0; i < NB && i < log_q.size(); i++)
      check($sformatf("bp_b%0d", i), {24'b0, log_q[i]}, {24'b0, exp1[i]});

    // Burst of 6 with ready low: one dropped, then 5 frames back-to-back.
    io_in_ready = 1'b0;
    for (int i = 0; i < 6; i++) commit(32'h1000 + i, 32'h2000 + i, 32'h3000 + i);
    cyc();
    check("burst_overflow", {31'b0, io_out_overflow}, 32'd1);
    check("burst_dropCnt", {16'b0, io_out_dropCnt}, 32'd1);
    io_in_ready = 1'b1;
    n = 0;
    while (io_out_valid && n < 500) begin n++; cyc(); end
    check("burst_valid_run", n, 5 * NB);

    // Full FIFO with a pop in the same cycle as the commit: accepted.
    io_in_ready = 1'b0;
    for (int i = 0; i < 5; i++) commit(32'h4000 + i, 32'h5000 + i, 32'h6000 + i);
    cyc(); cyc();
    drop_before = io_out_dropCnt;
    io_in_ready = 1'b1;
    repeat (NB - 1) cyc();
    commit(32'hCAFE_0000, 32'hBEEF_0000, 32'h1234_5678);
    check("fullpop_dropCnt", {16'b0, io_out_dropCnt}, drop_before);
    drain("fullpop");

    // Capture disabled: commits ignored.
    io_in_start = 1'b0;
    for (int i = 0; i < 5; i++) commit(32'h7000 + i, 32'h0, 32'h0);
    cyc();
    check("nostart_valid", {31'b0, io_out_valid}, 32'd0);
    check("nostart_busy", {31'b0, io_out_busy}, 32'd0);
    io_in_start = 1'b1;

    // Reset mid-frame, then a fresh frame.
    commit(32'h9000_0000, 32'h1, 32'h2);
    repeat (5) cyc();
    reset = 1'b0;
    #1;
    check("midrst_valid", {31'b0, io_out_valid}, 32'd0);
    check("midrst_dropCnt", {16'b0, io_out_dropCnt}, 32'd0);
    check("midrst_busy", {31'b0, io_out_busy}, 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    log_q.delete();
    commit(32'hA000_0000, 32'h3, 32'h4);
    drain("midrst");
    check("midrst_len", log_q.size(), NB);
    if (log_q.size() > 0) check("midrst_sync", {24'b0, log_q[0]}, 32'hA5);

`ifdef COMMIT_TX_SEQ_EN
    // Sequence numbers: burst drops seq 5, next commit carries seq 6.
    do_reset();
    io_in_start = 1'b1;
    log_q.delete();
    io_in_ready = 1'b0;
    for (int i = 0; i < 6; i++) commit(32'h100 + i, 32'h200 + i, 32'h300 + i);
    drain("seq_a");
    commit(32'h400, 32'h500, 32'h600);
    drain("seq_b");
    seqs = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd6};
    check("seq_len", log_q.size(), 6 * 14);
    for (int k = 0; k < 6 && (k * 14 + 1) < log_q.size(); k++) begin
      check($sformatf("seq_sync%0d", k), {24'b0, log_q[k*14]}, 32'hA5);
      check($sformatf("seq_val%0d", k), {24'b0, log_q[k*14+1]}, {24'b0, seqs[k]});
    end
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      io_in_start  = ($urandom_range(0, 9) != 0);
      io_in_commit = ($urandom_range(0, 1) == 1);
      io_in_ready  = ($urandom_range(0, 9) < 6);
      io_in_pc     = $urandom;
      io_in_inst   = $urandom;
      io_in_wbData = $urandom;
      cyc();
    end
    io_in_commit = 1'b0;
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
